mem_word_master: RTL and testbench

MEM_WORD_MASTER -- requirements
Module: mem_word_master

---
 rtl/mem_word_pkg.sv | 14 +
 rtl/mem_word_lane.sv | 34 +++
 rtl/mem_word_master.sv | 147 ++++++++++++++
 tb/tb_mem_word_master.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_word_pkg.sv
// Shared types and constants for the byte-serial word master.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mem_word_pkg;

   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mem_word_lane.sv
// Byte-lane steering: selects the big-endian write byte for a lane index and
// decodes a lane index into a one-hot read-lane write enable.
// Latency: combinational. Backpressure: none.
//
// Ports:
//   wr_k    - lane index for the outgoing write byte
//   wr_word - 32-bit word being written
//   wr_byte - wr_word byte for lane wr_k (lane 0 = bits 31:24)
//   rd_k    - lane index of the byte currently being read
//   rd_we   - one-hot enable, bit i set when rd_k == i
module mem_word_lane
   import mem_word_pkg::*;
(
   input  logic [1:0]                wr_k,
   input  logic [31:0]               wr_word,
   output logic [7:0]                wr_byte,
   input  logic [1:0]                rd_k,
   output logic [BYTES_PER_WORD-1:0] rd_we
);

   always_comb begin
      wr_byte = wr_word[31:24];
      case (wr_k)
         2'd0: wr_byte = wr_word[31:24];
         2'd1: wr_byte = wr_word[23:16];
         2'd2: wr_byte = wr_word[15:8];
         2'd3: wr_byte = wr_word[7:0];
         default: wr_byte = wr_word[31:24];
      endcase
   end

   assign rd_we = BYTES_PER_WORD'(1) << rd_k;

endmodule

// File: rtl/mem_word_master.sv
// Word master: turns one 32-bit read/write request into four byte cycles on
// a byte-wide memory, big-endian, base address aligned down to a word.
// Latency: response valid in the 5th cycle after acceptance (4 byte + 1 done).
// Backpressure: one transaction in flight; req_ready only in IDLE, the
//   response is held until rsp_ready and the retire cycle accepts nothing.
//
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   req_valid/req_ready        - request handshake
//   req_write/req_adr/req_wdata- request kind, byte address, write word
//   req_be                     - byte write mask (MEM_WORD_MASTER_BYTE_MASK_EN only)
//   rsp_valid/rsp_ready        - response handshake
//   rsp_rdata                  - assembled read word (untouched by writes)
//   memread/memwrite/adr/writedata/memdata - byte-wide memory port
//
// Optional feature macro: MEM_WORD_MASTER_BYTE_MASK_EN adds req_be; a cleared
// bit suppresses memwrite for that byte but keeps the 4-cycle timing.
module mem_word_master
   import mem_word_pkg::*;
#(
   parameter int WIDTH = 8
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [WIDTH-1:0] req_adr,
   input  logic [31:0]      req_wdata,
`ifdef MEM_WORD_MASTER_BYTE_MASK_EN
   input  logic [3:0]       req_be,
`endif
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_rdata,
   output logic             memread,
   output logic             memwrite,
   output logic [WIDTH-1:0] adr,
   output logic [WIDTH-1:0] writedata,
   input  logic [WIDTH-1:0] memdata
);

   state_t                    state;
   logic [1:0]                k;
   logic                      write_q;
   logic [WIDTH-1:0]          base_q;
   logic [31:0]               wdata_q;
   logic                      accept;
   logic [1:0]                nk;
   logic [31:0]               word_src;
   logic [3:0]                be_src;
   logic [WIDTH-1:0]          aligned_adr;
   logic [7:0]                wr_byte;
   logic [BYTES_PER_WORD-1:0] rd_we;

   assign req_ready   = (state == IDLE);
   assign accept      = req_valid & req_ready;
   assign aligned_adr = req_adr & ~WIDTH'(3);

   // Memory outputs are registered, so the lane logic works on the byte
   // index of the *next* cycle: 0 at acceptance, k+1 while transferring.
   assign nk       = accept ? 2'd0 : k + 2'd1;
   assign word_src = accept ? req_wdata : wdata_q;

`ifdef MEM_WORD_MASTER_BYTE_MASK_EN
   logic [3:0] be_q;
   assign be_src = accept ? req_be : be_q;
`else
   assign be_src = 4'hF;
`endif

   mem_word_lane u_lane (
      .wr_k    (nk),
      .wr_word (word_src),
      .wr_byte (wr_byte),
      .rd_k    (k),
      .rd_we   (rd_we)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         k         <= 2'd0;
         write_q   <= 1'b0;
         base_q    <= '0;
         wdata_q   <= '0;
         memread   <= 1'b0;
         memwrite  <= 1'b0;
         adr       <= '0;
         writedata <= '0;
         rsp_rdata <= '0;
         rsp_valid <= 1'b0;
`ifdef MEM_WORD_MASTER_BYTE_MASK_EN
         be_q      <= 4'h0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state     <= XFER;
                  k         <= 2'd0;
                  write_q   <= req_write;
                  base_q    <= aligned_adr;
                  wdata_q   <= req_wdata;
                  adr       <= aligned_adr;
                  memread   <= ~req_write;
                  memwrite  <= req_write & be_src[nk];
                  writedata <= WIDTH'(wr_byte);
`ifdef MEM_WORD_MASTER_BYTE_MASK_EN
                  be_q      <= req_be;
`endif
               end
            end
            XFER: begin
               // memdata is combinational from adr: capture the current byte
               if (!write_q) begin
                  for (int i = 0; i < BYTES_PER_WORD; i++) begin
                     if (rd_we[i])
                        rsp_rdata[31-8*i -: 8] <= memdata[7:0];
                  end
               end
               if (k == 2'd3) begin
                  state     <= DONE;
                  k         <= 2'd0;
                  memread   <= 1'b0;
                  memwrite  <= 1'b0;
                  rsp_valid <= 1'b1;
               end else begin
                  k         <= nk;
                  adr       <= base_q + WIDTH'(nk);
                  memwrite  <= write_q & be_src[nk];
                  writedata <= WIDTH'(wr_byte);
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_word_master.sv
// Directed bench for mem_word_master with a 256-byte memory attached.
// Latency: n/a. Backpressure: rsp_ready driven by the stimulus.
module tb_mem_word_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [7:0]  req_adr;
   logic [31:0] req_wdata;
   logic [3:0]  wr_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        memread;
   logic        memwrite;
   logic [7:0]  adr;
   logic [7:0]  writedata;
   logic [7:0]  memdata;

   logic        tb_load;
   logic [7:0]  mem [0:255];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_word_master #(.WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_adr   (req_adr),
      .req_wdata (req_wdata),
`ifdef MEM_WORD_MASTER_BYTE_MASK_EN
      .req_be    (wr_be),
`endif
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .memread   (memread),
      .memwrite  (memwrite),
      .adr       (adr),
      .writedata (writedata),
      .memdata   (memdata)
   );

   // External byte memory: combinational read, write on the clock edge.
   assign memdata = mem[adr];

   always @(posedge clk) begin
      if (tb_load) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
         mem[8'h40] <= 8'h12;
         mem[8'h41] <= 8'h34;
         mem[8'h42] <= 8'h56;
         mem[8'h43] <= 8'h78;
      end else if (memwrite) begin
         mem[adr] <= writedata;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_read(input logic [7:0] a, input logic [7:0] base,
                          input logic [31:0] exp, input int hold, input bit chain);
      logic [7:0] ea;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_adr   = a;
      rsp_ready = 1'b0;
      chk("rd_req_ready", 32'(req_ready), 32'd1);
      step();
      req_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         ea = base + 8'(k);
         chk("rd_adr",      32'(adr),       32'(ea));
         chk("rd_memread",  32'(memread),   32'd1);
         chk("rd_memwrite", 32'(memwrite),  32'd0);
         chk("rd_rsp_early",32'(rsp_valid), 32'd0);
         step();
      end
      chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rd_rdata",     rsp_rdata,      exp);
      chk("rd_done_mem",  32'(memread),   32'd0);
      chk("rd_done_rdy",  32'(req_ready), 32'd0);
      for (int h = 0; h < hold; h++) begin
         step();
         chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_rdata",     rsp_rdata,      exp);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         chk("bp_mem",       32'({memread, memwrite}), 32'd0);
      end
      if (chain) begin
         req_valid = 1'b1;
         req_write = 1'b0;
         req_adr   = 8'hFC;
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("rt_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rt_req_ready", 32'(req_ready), 32'd1);
      chk("rt_no_accept", 32'({memread, memwrite}), 32'd0);
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] base,
                           input logic [31:0] data, input logic [3:0] be,
                           input logic [31:0] prev);
      logic [7:0] ea;
      logic [31:0] d;
      d         = data;
      wr_be     = be;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_adr   = a;
      req_wdata = data;
      rsp_ready = 1'b0;
      chk("wr_req_ready", 32'(req_ready), 32'd1);
      step();
      req_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         ea = base + 8'(k);
         chk("wr_adr",      32'(adr),      32'(ea));
         chk("wr_memwrite", 32'(memwrite), 32'(be[k]));
         chk("wr_memread",  32'(memread),  32'd0);
         if (be[k]) chk("wr_data", 32'(writedata), 32'(d[31-8*k -: 8]));
         step();
      end
      chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("wr_rdata_kept", rsp_rdata,     prev);
      chk("wr_done_mem",  32'(memwrite),  32'd0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("wr_rt_valid",  32'(rsp_valid), 32'd0);
      wr_be = 4'hF;
   endtask

   initial begin
      reset     = 1'b1;
      tb_load   = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_adr   = 8'h00;
      req_wdata = 32'h0;
      wr_be     = 4'hF;
      rsp_ready = 1'b0;
      step();
      step();
      tb_load = 1'b0;

      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_memread",   32'(memread),   32'd0);
      chk("rst_memwrite",  32'(memwrite),  32'd0);
      chk("rst_adr",       32'(adr),       32'd0);
      chk("rst_writedata", 32'(writedata), 32'd0);
      chk("rst_rdata",     rsp_rdata,      32'd0);
      reset = 1'b0;
      step();
      chk("idle_req_ready", 32'(req_ready), 32'd1);

      // Aligned read of 0x40..0x43
      do_read(8'h40, 8'h40, 32'h12345678, 0, 1'b0);
      // Write at top of the address space, rdata must keep the last read
      do_write(8'hFC, 8'hFC, 32'hCAFEF00D, 4'hF, 32'h12345678);
      // Unaligned request behaves like the aligned one
      do_read(8'h43, 8'h40, 32'h12345678, 0, 1'b0);
      // Backpressure for 10 cycles; next request held during retire cycle
      do_read(8'h40, 8'h40, 32'h12345678, 10, 1'b1);
      // Read-back of the earlier write, accepted the cycle after retire
      do_read(8'hFC, 8'hFC, 32'hCAFEF00D, 0, 1'b0);

      // Reset in XFER k=2 of a write to 0x80
      req_valid = 1'b1;
      req_write = 1'b1;
      req_adr   = 8'h80;
      req_wdata = 32'h11223344;
      step();
      req_valid = 1'b0;
      step();
      step();
      chk("ab_k2_adr",      32'(adr),      32'h82);
      chk("ab_k2_memwrite", 32'(memwrite), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("ab_req_ready", 32'(req_ready), 32'd1);
      chk("ab_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("ab_mem",       32'({memread, memwrite}), 32'd0);
      chk("ab_adr",       32'(adr),       32'd0);
      chk("ab_writedata", 32'(writedata), 32'd0);
      chk("ab_rdata",     rsp_rdata,      32'd0);
      for (int i = 0; i < 6; i++) begin
         step();
         chk("ab_quiet", 32'({memwrite, rsp_valid}), 32'd0);
      end
      // Bytes 0x80..0x82 landed before/at the reset edge, 0x83 never did
      do_read(8'h80, 8'h80, 32'h11223300, 0, 1'b0);

`ifdef MEM_WORD_MASTER_BYTE_MASK_EN
      do_write(8'h00, 8'h00, 32'hAABBCCDD, 4'b0101, 32'h11223300);
      do_read(8'h00, 8'h00, 32'hAA00CC00, 0, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
